// File: rtl/fx2fp_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : fx2fp_scheduler
// Brief    : Round-robin front end for a shared fixed-to-float converter with a
//            credit-limited, in-order result FIFO.
// Revision : 1.0 - initial release
// =============================================================================
module fx2fp_scheduler #(
    parameter int CONV_LAT  = 1,
    parameter int OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid_i,
    input  logic [20:0] req0_data_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [20:0] req1_data_i,
    output logic        req1_ready_o,
    output logic        conv_sign_o,
    output logic        conv_integer_o,
    output logic [18:0] conv_fractional_o,
    input  logic [31:0] conv_fp_i,
    output logic        res_valid_o,
    output logic        res_tag_o,
    output logic [31:0] res_fp_o,
    input  logic        res_ready_i,
    output logic        busy_o,
    output logic [15:0] res_count_o
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [CONV_LAT-1:0] pipe_valid;
    logic [CONV_LAT-1:0] pipe_tag;
    logic [3:0]          in_flight;
    logic [3:0]          occupancy;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [32:0]         fifo_mem [OUT_DEPTH];
    logic                last_grant;
    logic                grant1;
    logic                credit_ok;
    logic                accept;
    logic                push;
    logic                pop;
    logic [20:0]         sel_data;
    logic [15:0]         pop_count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < CONV_LAT; i++) begin
            in_flight = in_flight + {3'b000, pipe_valid[i]};
        end
    end

    // Credits cover everything accepted but not yet popped; no pop lookahead.
    assign credit_ok = (in_flight + occupancy) < 4'(OUT_DEPTH);

    always_comb begin
        if (req0_valid_i && req1_valid_i) begin
            grant1 = ~last_grant;
        end else begin
            grant1 = req1_valid_i;
        end
    end

    assign req0_ready_o = rst_n & credit_ok & req0_valid_i & ~grant1;
    assign req1_ready_o = rst_n & credit_ok & req1_valid_i &  grant1;
    assign accept       = req0_ready_o | req1_ready_o;
    assign sel_data     = grant1 ? req1_data_i : req0_data_i;

    assign {conv_sign_o, conv_integer_o, conv_fractional_o} = accept ? sel_data : 21'd0;

    assign push        = pipe_valid[CONV_LAT-1];
    assign res_valid_o = (occupancy != 4'd0);
    assign pop         = res_valid_o & res_ready_i;
    assign busy_o      = (in_flight != 4'd0) | res_valid_o;
    assign res_count_o = pop_count;

    assign {res_tag_o, res_fp_o} = res_valid_o ? fifo_mem[rd_ptr] : 33'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            pipe_tag   <= '0;
            occupancy  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            last_grant <= 1'b1;
            pop_count  <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_tag[0]   <= grant1;
            for (int i = 1; i < CONV_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
            if (accept) begin
                last_grant <= grant1;
            end
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= ptr_next(rd_ptr);
                pop_count <= pop_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 4'd1;
                2'b01:   occupancy <= occupancy - 4'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible behind occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pipe_tag[CONV_LAT-1], conv_fp_i};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fx2fp_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_fx2fp_scheduler
// Brief    : Self-checking bench for fx2fp_scheduler with a transaction model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fx2fp_scheduler;

    localparam int LAT   = 1;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [20:0] req0_data, req1_data;
    logic        conv_sign, conv_integer;
    logic [18:0] conv_fractional;
    logic [31:0] conv_fp;
    logic        res_valid, res_tag, res_ready, busy;
    logic [31:0] res_fp;
    logic [15:0] res_count;
    logic [20:0] conv_q;

    fx2fp_scheduler #(.CONV_LAT(LAT), .OUT_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_ready_o(req0_ready),
        .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_ready_o(req1_ready),
        .conv_sign_o(conv_sign), .conv_integer_o(conv_integer), .conv_fractional_o(conv_fractional),
        .conv_fp_i(conv_fp),
        .res_valid_o(res_valid), .res_tag_o(res_tag), .res_fp_o(res_fp), .res_ready_i(res_ready),
        .busy_o(busy), .res_count_o(res_count)
    );

    always @(posedge clk) conv_q <= {conv_sign, conv_integer, conv_fractional};
    assign conv_fp = {11'b0, conv_q};

    // Deeper-FIFO instance sustains one pop per cycle for the counter wrap run.
    logic        wr_req0_valid, wr_req1_valid, wr_req0_ready, wr_req1_ready;
    logic [20:0] wr_req0_data, wr_req1_data;
    logic        wr_conv_sign, wr_conv_integer;
    logic [18:0] wr_conv_fractional;
    logic [31:0] wr_conv_fp;
    logic        wr_res_valid, wr_res_tag, wr_res_ready, wr_busy;
    logic [31:0] wr_res_fp;
    logic [15:0] wr_res_count;
    logic [20:0] wr_conv_q;

    fx2fp_scheduler #(.CONV_LAT(1), .OUT_DEPTH(4)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(wr_req0_valid), .req0_data_i(wr_req0_data), .req0_ready_o(wr_req0_ready),
        .req1_valid_i(wr_req1_valid), .req1_data_i(wr_req1_data), .req1_ready_o(wr_req1_ready),
        .conv_sign_o(wr_conv_sign), .conv_integer_o(wr_conv_integer), .conv_fractional_o(wr_conv_fractional),
        .conv_fp_i(wr_conv_fp),
        .res_valid_o(wr_res_valid), .res_tag_o(wr_res_tag), .res_fp_o(wr_res_fp), .res_ready_i(wr_res_ready),
        .busy_o(wr_busy), .res_count_o(wr_res_count)
    );

    always @(posedge clk) wr_conv_q <= {wr_conv_sign, wr_conv_integer, wr_conv_fractional};
    assign wr_conv_fp = {11'b0, wr_conv_q};

    // Transaction model: outstanding = accepted - popped; results appear LAT+1 cycles after accept.
    typedef struct {
        logic        tag;
        logic [20:0] data;
        int          arrive;
    } item_t;

    item_t q[$];
    int    outstanding;
    int    cyc;
    int    model_pops;
    logic  last_g;
    int    n_checks = 0;
    int    n_fail   = 0;

    typedef struct {
        int          pre;
        logic        v0;
        logic [20:0] d0;
        logic        v1;
        logic [20:0] d1;
        logic        r0;
        logic        r1;
        logic [20:0] conv;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        outstanding = 0;
        model_pops  = 0;
        last_g      = 1'b1;
    endtask

    task automatic step(input logic v0, input logic [20:0] d0, input logic v1,
                        input logic [20:0] d1, input logic rdy);
        logic        g, acc, head;
        logic [20:0] exp_conv;
        @(negedge clk);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        res_ready  = rdy;
        #1;
        g        = (v0 && v1) ? ~last_g : v1;
        acc      = (outstanding < DEPTH) && (v0 || v1);
        exp_conv = acc ? (g ? d1 : d0) : 21'd0;
        head     = (q.size() > 0) && (q[0].arrive <= cyc);
        check("req0_ready", 64'(req0_ready), 64'(acc && !g));
        check("req1_ready", 64'(req1_ready), 64'(acc && g));
        check("conv_bus", 64'({conv_sign, conv_integer, conv_fractional}), 64'(exp_conv));
        check("res_valid", 64'(res_valid), 64'(head));
        if (head) begin
            check("res_tag", 64'(res_tag), 64'(q[0].tag));
            check("res_fp", 64'(res_fp), 64'({11'b0, q[0].data}));
        end
        check("busy", 64'(busy), 64'(outstanding != 0));
        check("res_count", 64'(res_count), 64'(model_pops[15:0]));
        if (acc) begin
            q.push_back('{g, (g ? d1 : d0), cyc + LAT + 1});
            outstanding++;
            last_g = g;
        end
        if (head && rdy) begin
            void'(q.pop_front());
            outstanding--;
            model_pops++;
        end
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && outstanding > 0; k++) step(1'b0, 21'd0, 1'b0, 21'd0, 1'b1);
        step(1'b0, 21'd0, 1'b0, 21'd0, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_data  = '0;   req1_data  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int   nacc;
        int   ng;
        int   rdy_pct;
        int   pops_w;
        int   guard;
        logic exp_next;
        logic seen_ffff;

        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_data = '0; req1_data = '0;
        wr_req0_valid = 1'b0; wr_req1_valid = 1'b0; wr_res_ready = 1'b0;
        wr_req0_data = 21'h000001; wr_req1_data = '0;
        cyc = 0;
        model_reset();

        #1 rst_n = 1'b0;
        #2;
        req0_valid = 1'b1; req0_data = 21'h1FFFFF;
        req1_valid = 1'b1; req1_data = 21'h155555;
        #1;
        check("rst_req0_ready", 64'(req0_ready), 64'd0);
        check("rst_req1_ready", 64'(req1_ready), 64'd0);
        check("rst_conv", 64'({conv_sign, conv_integer, conv_fractional}), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_fp", 64'({res_tag, res_fp}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(res_count), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Arbitration / conv bus table; pre: 0 none, 1 accept req0, 2 accept req1, 3 fill credits.
        tbl[0] = '{0, 1'b0, 21'h000000, 1'b0, 21'h000000, 1'b0, 1'b0, 21'h000000};
        tbl[1] = '{0, 1'b1, 21'h1ABCDE, 1'b0, 21'h000000, 1'b1, 1'b0, 21'h1ABCDE};
        tbl[2] = '{0, 1'b0, 21'h000000, 1'b1, 21'h0F0F0F, 1'b0, 1'b1, 21'h0F0F0F};
        tbl[3] = '{0, 1'b1, 21'h123456, 1'b1, 21'h0FEDCB, 1'b1, 1'b0, 21'h123456};
        tbl[4] = '{1, 1'b1, 21'h111111, 1'b1, 21'h022222, 1'b0, 1'b1, 21'h022222};
        tbl[5] = '{2, 1'b1, 21'h133333, 1'b1, 21'h044444, 1'b1, 1'b0, 21'h133333};
        tbl[6] = '{1, 1'b1, 21'h0ABCDE, 1'b0, 21'h000000, 1'b1, 1'b0, 21'h0ABCDE};
        tbl[7] = '{3, 1'b1, 21'h077777, 1'b1, 21'h088888, 1'b0, 1'b0, 21'h000000};

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].pre == 3) begin
                step(1'b1, 21'h000011, 1'b0, 21'd0, 1'b0);
                step(1'b1, 21'h000022, 1'b0, 21'd0, 1'b0);
            end else if (tbl[i].pre != 0) begin
                step(tbl[i].pre == 1, 21'h00AAAA, tbl[i].pre == 2, 21'h005555, 1'b1);
                drain();
            end
            @(negedge clk);
            req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_data = tbl[i].d1;
            res_ready  = 1'b0;
            #1;
            check($sformatf("vec%0d_ready0", i), 64'(req0_ready), 64'(tbl[i].r0));
            check($sformatf("vec%0d_ready1", i), 64'(req1_ready), 64'(tbl[i].r1));
            check($sformatf("vec%0d_conv", i),
                  64'({conv_sign, conv_integer, conv_fractional}), 64'(tbl[i].conv));
            #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        drain();

        // Single conversion
        apply_reset();
        step(1'b1, 21'h040000, 1'b0, 21'd0, 1'b1);
        check("single_accept", 64'(req0_ready), 64'd1);
        step(1'b0, 21'd0, 1'b0, 21'd0, 1'b1);
        check("single_gap", 64'(res_valid), 64'd0);
        step(1'b0, 21'd0, 1'b0, 21'd0, 1'b1);
        check("single_valid", 64'(res_valid), 64'd1);
        check("single_tag", 64'(res_tag), 64'd0);
        check("single_fp", 64'(res_fp), 64'h00040000);
        step(1'b0, 21'd0, 1'b0, 21'd0, 1'b1);
        check("single_count", 64'(res_count), 64'd1);

        // Tie: grants alternate starting with requester 0
        apply_reset();
        ng = 0;
        exp_next = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step(1'b1, 21'h000001, 1'b1, 21'h000002, 1'b1);
            if (req0_ready || req1_ready) begin
                check($sformatf("tie_grant%0d", ng), 64'(req1_ready), 64'(exp_next));
                exp_next = ~exp_next;
                ng++;
            end
        end
        check("tie_grant_total", 64'(ng >= 8), 64'd1);
        drain();

        // Backpressure: two credits, then one accept per pop
        apply_reset();
        nacc = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 21'(k + 16), 1'b0, 21'd0, 1'b0);
            if (req0_ready) nacc++;
        end
        check("bp_accepts", 64'(nacc), 64'd2);
        for (int k = 0; k < 12; k++) step(1'b1, 21'(k + 32), 1'b0, 21'd0, 1'b1);
        drain();

        // Reset one cycle after an accept
        apply_reset();
        step(1'b1, 21'h00DEAD, 1'b0, 21'd0, 1'b1);
        step(1'b0, 21'd0, 1'b0, 21'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_res_valid", 64'(res_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("midrst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 21'd0, 1'b0, 21'd0, 1'b1);
        step(1'b1, 21'h000003, 1'b1, 21'h000004, 1'b1);
        check("midrst_tie_req0", 64'(req0_ready), 64'd1);
        drain();

        // Randomized traffic with varying downstream readiness
        apply_reset();
        for (int blk = 0; blk < 15; blk++) begin
            rdy_pct = $urandom_range(10, 100);
            for (int k = 0; k < 200; k++) begin
                step($urandom_range(0, 99) < 60, 21'($urandom),
                     $urandom_range(0, 99) < 60, 21'($urandom),
                     $urandom_range(1, 100) <= rdy_pct);
            end
        end
        drain();

        // Result counter wrap on the deep-FIFO instance
        @(negedge clk);
        wr_req0_valid = 1'b1;
        wr_res_ready  = 1'b1;
        pops_w    = 0;
        guard     = 0;
        seen_ffff = 1'b0;
        while (pops_w < 65536 && guard < 70000) begin
            @(negedge clk);
            #1;
            if (pops_w == 65535 && !seen_ffff) begin
                check("wrap_ffff", 64'(wr_res_count), 64'hFFFF);
                seen_ffff = 1'b1;
            end
            if (wr_res_valid) pops_w++;
            guard++;
        end
        if (pops_w < 65536) begin
            n_checks++;
            n_fail++;
            $display("FAIL wrap_timeout: got %0d pops, expected 65536", pops_w);
        end
        @(negedge clk);
        #1;
        check("wrap_zero", 64'(wr_res_count), 64'h0000);
        wr_req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        wr_res_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
